// File: rtl/mem_access_pkg.sv
// Shared encodings for the data-memory load/store initiator.
package mem_access_pkg;

    localparam int unsigned LANES  = 4;
    localparam int unsigned DATA_W = LANES * 8;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        RESP = 2'b11
    } state_t;

    // Lowest byte lane touched by an access; sub-word alignment bits are forced to 0.
    function automatic logic [1:0] lane_of(input logic [1:0] size, input logic [1:0] a);
        case (size)
            SZ_BYTE: lane_of = a;
            SZ_HALF: lane_of = {a[1], 1'b0};
            default: lane_of = 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_lane_merge.sv
// Byte-lane store merge and load extract/extend for one 32-bit memory word.
module lane_merge
    import mem_access_pkg::*;
(
    input  logic [DATA_W-1:0] word,
    input  logic [DATA_W-1:0] wdata,
    input  logic [1:0]        size,
    input  logic [1:0]        lane,
    input  logic              uns,
    output logic [DATA_W-1:0] merged,
    output logic [DATA_W-1:0] loaded
);

    logic [DATA_W-1:0] shifted;

    always_comb begin
        merged  = word;
        shifted = word >> {lane, 3'b000};
        loaded  = '0;
        case (size)
            SZ_BYTE: begin
                merged[{lane, 3'b000} +: 8] = wdata[7:0];
                loaded = uns ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
            end
            SZ_HALF: begin
                merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
                loaded = uns ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            end
            SZ_WORD: begin
                merged = wdata;
                loaded = word;
            end
            default: begin
                merged = word;
                loaded = '0;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Multi-cycle byte/half/word load-store initiator with read-modify-write for sub-word stores.
// Optional alignment faulting is enabled with MEM_ACCESS_ALIGN_CHECK_EN.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              uns,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              ready,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              err,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_we,
    output logic [31:0]       mem_wd,
    input  logic [31:0]       mem_rd
);

    localparam int unsigned IDX_W = ADDR_W - 2;

    state_t            state, state_nx;
    logic              we_q, uns_q, fault_q;
    logic [1:0]        size_q, lane_q;
    logic [IDX_W-1:0]  idx_q;
    logic [31:0]       wdata_q, buf_q;

    logic              accept_c, fault_c;
    logic [1:0]        lane_c;
    logic [31:0]       lm_word_c, merged_c, loaded_c;

    // Fault classification of the request presented at accept.
    always_comb begin
        accept_c = req && (state == IDLE);
        lane_c   = lane_of(size, addr[1:0]);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
        fault_c  = (size == SZ_RSVD)
                || ((size == SZ_HALF) && addr[0])
                || ((size == SZ_WORD) && (addr[1:0] != 2'b00));
`else
        fault_c  = (size == SZ_RSVD);
`endif
    end

    // Extract reads the live memory word in RD; merge uses the buffered word in WR.
    assign lm_word_c = (state == RD) ? mem_rd : buf_q;

    lane_merge u_lane_merge (
        .word   (lm_word_c),
        .wdata  (wdata_q),
        .size   (size_q),
        .lane   (lane_q),
        .uns    (uns_q),
        .merged (merged_c),
        .loaded (loaded_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        ready    = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        mem_a    = '0;
        mem_we   = 1'b0;
        mem_wd   = '0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (req) state_nx = RD;
            end
            RD: begin
                mem_a    = {idx_q, 2'b00};
                state_nx = (we_q && !fault_q) ? WR : RESP;
            end
            WR: begin
                mem_a    = {idx_q, 2'b00};
                mem_we   = rst_n;
                mem_wd   = merged_c;
                state_nx = RESP;
            end
            RESP: begin
                mem_a    = {idx_q, 2'b00};
                done     = 1'b1;
                err      = fault_q;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Request capture, line buffer and load result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            fault_q <= 1'b0;
            size_q  <= SZ_BYTE;
            lane_q  <= 2'b00;
            idx_q   <= '0;
            wdata_q <= '0;
            buf_q   <= '0;
            rdata   <= '0;
        end else begin
            if (accept_c) begin
                we_q    <= we;
                uns_q   <= uns;
                fault_q <= fault_c;
                size_q  <= size;
                lane_q  <= lane_c;
                idx_q   <= addr[ADDR_W-1:2];
                wdata_q <= wdata;
            end
            if (state == RD) begin
                buf_q <= mem_rd;
                if (fault_q)    rdata <= '0;
                else if (!we_q) rdata <= loaded_c;
            end
        end
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Multi-cycle load/store initiator that sits between the CPU datapath and the word-organised data memory. It accepts one byte/halfword/word request at a time, drives the memory's address/write-enable/write-data port, and performs read-modify-write for sub-word stores. Loads return zero- or sign-extended data. It is the requester side of the data-memory port: the memory reads asynchronously and writes on the rising clock edge.

## Interface
- ADDR_W, 6: byte-address width of the data memory; word index is addr[ADDR_W-1:2].
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req  in  1  request strobe; accepted when req && ready.
- we  in  1  1 = store, 0 = load; sampled at accept.
- size  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved; sampled at accept.
- uns  in  1  load zero-extend when 1, sign-extend when 0; sampled at accept.
- addr  in  ADDR_W  byte address; sampled at accept.
- wdata  in  32  store data, right-aligned; sampled at accept.
- ready  out  1  high only in IDLE.
- done  out  1  one-cycle pulse ending every accepted request.
- rdata  out  32  load result; valid while done=1, holds until the next done.
- err  out  1  qualifies done; request faulted (misaligned or size 11).
- mem_a  out  ADDR_W  memory address, always word-aligned: {word index, 2'b00}.
- mem_we  out  1  memory write enable.
- mem_wd  out  32  memory write data.
- mem_rd  in  32  memory read data (combinational from mem_a).

## Operation
- FSM states: IDLE, RD, WR, RESP.
  - IDLE: ready=1. On req, capture we/size/uns/addr/wdata and go to RD.
  - RD: drive mem_a and register mem_rd into the line buffer. Next state is WR for a store, RESP for a load.
  - WR: mem_we=1 and mem_wd=merged word. Next state is RESP.
  - RESP: done=1. Next state is IDLE.
- Byte lanes are little-endian: lane k = bits 8k+7:8k, and lane = addr[1:0].
- Byte access uses lane addr[1:0]. Half access uses lanes addr[1]*2 and addr[1]*2+1. Word access uses all lanes.
- Store merge: replace the selected lanes of the buffered word with wdata[7:0] or wdata[15:0]. Word stores write wdata unmodified; RD is still visited to keep latency uniform.
- Load extract: shift the selected lanes to bit 0, then extend from bit 7 or 15 per uns. Word loads ignore uns.
- Size 11 always faults. err=1 at done, there is no memory write, and rdata=0.
- req while busy (not IDLE) is ignored and is not queued.
- Reset (rst_n=0 at an edge) takes the FSM to IDLE from any state. All registers clear: rdata=0, buffer=0.
- mem_we = (state==WR) && rst_n. This means a write is suppressed when reset is asserted in the WR cycle. A store aborted by reset never writes.
- Reset values of outputs: ready=1 (IDLE), done=0, err=0, rdata=0, mem_we=0, mem_a=0, mem_wd=0.

## Timing
- Accept edge is T0.
  - Load: RD during T0–T1, done during cycle T2.
  - Store: RD during T0–T1, WR during T1–T2 (memory updated at edge T2), done during cycle T3.
- Load latency is 2 cycles from accept to done, with one accept every 3 cycles. Store latency is 3 cycles, with one accept every 4 cycles.
- ready drops the cycle after accept and returns the cycle after done.
- A faulted request follows the load path (RD → RESP) regardless of we, with mem_we held 0.
- mem_a holds the captured word address from RD through RESP and is 0 in IDLE.
- mem_wd = merged word in WR, otherwise 0.

## Configuration
- MEM_ACCESS_ALIGN_CHECK_EN defined:
  - Half access with addr[0]=1 faults.
  - Word access with addr[1:0]≠00 faults.
  - A fault means err=1, no write, and rdata=0.
- Not defined:
  - Misalignment is never reported. Half forces addr[0]=0 and word forces addr[1:0]=00 before lane selection.
  - err is raised only for size 11.

## Structure
- Shared package mem_access_pkg holds:
  - Size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - FSM state encoding.
  - Lane count constant 4.
- One combinational sub-module, lane_merge. Inputs: word, wdata, size, lane. Outputs: merged store word and extracted/extended load value. Both ports of the FSM use it.

## Test plan
- After reset, word store of 0xDEADBEEF at addr 0x08, then word load at 0x08 → rdata=0xDEADBEEF, err=0. Done arrives 3 and 2 cycles after accept respectively.
- Memory word 0x11223344 at 0x0C. Byte store 0xAA at 0x0D → memory 0x1122AA44. Signed byte load 0x0D → 0xFFFFFFAA. Unsigned byte load → 0x000000AA.
- Half store 0x8001 at 0x12 over 0x00000000 → memory 0x80010000. Signed half load 0x12 → 0xFFFF8001.
- Half store at 0x05 with MEM_ACCESS_ALIGN_CHECK_EN → err=1, mem_we never asserted. Without the macro → write to lanes 0–1 of word 0x04.
- Store of 0x5 to 0x10, then rst_n=0 during the WR cycle → FSM returns to IDLE, mem_we=0 in that cycle, memory unchanged, done never pulses.
- req held high continuously → exactly one accept per ready window. Requests issued while busy produce no extra done pulses.
